ehl_gpio_bank: RTL and testbench

//  Next-generation GPIO bank: WIDTH pins with a simple addressed register port in place of per-register strobes.

---
 rtl/ehl_gpio_bank.sv | 173 +++++++++++++++++
 tb/tb_ehl_gpio_bank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_gpio_bank.sv
// GPIO bank with an addressed register port, per-pin debounce, four interrupt modes
// and atomic set/clear/invert of the output data register.
module ehl_gpio_bank #(
    parameter int               WIDTH        = 32,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DBW          = 8,
    parameter logic [WIDTH-1:0] GDOR_INIT    = '0,
    parameter logic [WIDTH-1:0] GOER_INIT    = '0,
    parameter logic [WIDTH-1:0] GAFR_INIT    = '0,
    parameter logic [WIDTH-1:0] GPER_INIT    = '0,
    parameter logic [WIDTH-1:0] GPTR_INIT    = '0,
    parameter bit               IRQ_POLARITY = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [3:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gdor,
    output logic [WIDTH-1:0] goer,
    output logic [WIDTH-1:0] gafr,
    output logic [WIDTH-1:0] pull_up,
    output logic [WIDTH-1:0] pull_down,
    output logic             irq
);
    localparam int PW = (WIDTH > DBW) ? WIDTH : DBW;

    logic [WIDTH-1:0] gdor_q, gdor_d, goer_q, gafr_q, gper_q, gptr_q;
    logic [WIDTH-1:0] gier_q, gim0_q, gim1_q, gifr_q, gifr_d, gdbe_q;
    logic [WIDTH-1:0] gdir_q, gdir_d, prev_q, rdata_q, rd_mux;
    logic [DBW-1:0]   gdbt_q;
    logic             irq_q;
    logic [WIDTH-1:0] s, fall, rise, evt, qual, w1c;
    logic [PW-1:0]    wdata_pad, gdbt_pad;

    assign wdata_pad = PW'(wdata);
    assign gdbt_pad  = PW'(gdbt_q);

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = gpio_in;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= gpio_in;
                    for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Debounce: a mismatch must persist for GDBT+1 cycles before GDIR follows.
    // The >= compare keeps the counter from running past a lowered GDBT.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            logic [DBW-1:0] cnt_q, cnt_d;
            logic           dir_d;
            always_comb begin
                dir_d = gdir_q[gi];
                cnt_d = '0;
                if (!gdbe_q[gi]) begin
                    dir_d = s[gi];
                end else if (s[gi] != gdir_q[gi]) begin
                    if (cnt_q >= gdbt_q) dir_d = s[gi];
                    else                 cnt_d = cnt_q + 1'b1;
                end
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) cnt_q <= '0;
                else          cnt_q <= cnt_d;
            end
            assign gdir_d[gi] = dir_d;
        end
    endgenerate

    assign fall = prev_q & ~gdir_q;
    assign rise = ~prev_q & gdir_q;
    assign evt  = (~gim1_q & ~gim0_q & fall) | (~gim1_q & gim0_q & rise)
                | (gim1_q & ~gim0_q & (fall | rise)) | (gim1_q & gim0_q & gdir_q);
    assign qual = evt & gier_q & ~goer_q & ~gafr_q;
    assign w1c  = (wr && addr == 4'hB) ? wdata : '0;
    // New events override a simultaneous clear.
    assign gifr_d = (gifr_q & ~w1c) | qual;

    always_comb begin
        gdor_d = gdor_q;
        if (wr) begin
            case (addr)
                4'h0:    gdor_d = wdata;
                4'h1:    gdor_d = gdor_q | wdata;
                4'h2:    gdor_d = gdor_q & ~wdata;
                4'h3:    gdor_d = gdor_q ^ wdata;
                default: gdor_d = gdor_q;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            4'h0, 4'h1, 4'h2, 4'h3: rd_mux = gdor_q;
            4'h4:    rd_mux = goer_q;
            4'h5:    rd_mux = gafr_q;
            4'h6:    rd_mux = gper_q;
            4'h7:    rd_mux = gptr_q;
            4'h8:    rd_mux = gier_q;
            4'h9:    rd_mux = gim0_q;
            4'hA:    rd_mux = gim1_q;
            4'hB:    rd_mux = gifr_q;
            4'hC:    rd_mux = gdir_q;
            4'hD:    rd_mux = gdbe_q;
            4'hE:    rd_mux = gdbt_pad[WIDTH-1:0];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gdor_q  <= GDOR_INIT;
            goer_q  <= GOER_INIT;
            gafr_q  <= GAFR_INIT;
            gper_q  <= GPER_INIT;
            gptr_q  <= GPTR_INIT;
            gier_q  <= '0;
            gim0_q  <= '0;
            gim1_q  <= '0;
            gdbe_q  <= '0;
            gdbt_q  <= '0;
            gifr_q  <= '0;
            gdir_q  <= '0;
            prev_q  <= '0;
            rdata_q <= '0;
            irq_q   <= ~IRQ_POLARITY;
        end else begin
            gdor_q <= gdor_d;
            gifr_q <= gifr_d;
            gdir_q <= gdir_d;
            prev_q <= gdir_q;
            irq_q  <= (|gifr_d) ^ ~IRQ_POLARITY;
            if (rd) rdata_q <= rd_mux;
            if (wr) begin
                case (addr)
                    4'h4:    goer_q <= wdata;
                    4'h5:    gafr_q <= wdata;
                    4'h6:    gper_q <= wdata;
                    4'h7:    gptr_q <= wdata;
                    4'h8:    gier_q <= wdata;
                    4'h9:    gim0_q <= wdata;
                    4'hA:    gim1_q <= wdata;
                    4'hD:    gdbe_q <= wdata;
                    4'hE:    gdbt_q <= wdata_pad[DBW-1:0];
                    default: ;
                endcase
            end
        end
    end

    assign rdata     = rdata_q;
    assign gdor      = gdor_q;
    assign goer      = goer_q;
    assign gafr      = gafr_q;
    assign pull_up   = gper_q & gptr_q;
    assign pull_down = gper_q & ~gptr_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_ehl_gpio_bank.sv
// Scoreboarded bench for ehl_gpio_bank: a pin-level reference model queues expected read data,
// a negedge monitor pops it and also compares the pad-side outputs every cycle.
module tb_ehl_gpio_bank;
    localparam int W = 32;
    localparam int S = 2;
    localparam logic [31:0] P_GDOR = 32'h1234_0000;
    localparam logic [31:0] P_GPER = 32'h0000_FF00;
    localparam logic [31:0] P_GPTR = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        reset_n, wr, rd;
    logic [3:0]  addr;
    logic [31:0] wdata, rdata, gpio_in, gdor, goer, gafr, pull_up, pull_down;
    logic        irq;

    ehl_gpio_bank #(.WIDTH(W), .SYNC_STAGES(S), .DBW(8), .GDOR_INIT(P_GDOR),
                    .GPER_INIT(P_GPER), .GPTR_INIT(P_GPTR), .IRQ_POLARITY(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .gpio_in(gpio_in), .gdor(gdor), .goer(goer), .gafr(gafr),
        .pull_up(pull_up), .pull_down(pull_down), .irq(irq));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file plus per-pin input pipeline held as plain values.
    logic [31:0] pipe [S];
    logic [31:0] m_gdor, m_goer, m_gafr, m_gper, m_gptr, m_gier, m_gim0, m_gim1;
    logic [31:0] m_gifr, m_gdir, m_prev, m_gdbe, exp_rdata;
    int          m_dbt;
    int          m_cnt [W];
    bit          m_irq, rd_pend;
    logic [31:0] rdq [$];

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            0, 1, 2, 3: return m_gdor;
            4: return m_goer;   5: return m_gafr;  6: return m_gper;  7: return m_gptr;
            8: return m_gier;   9: return m_gim0; 10: return m_gim1; 11: return m_gifr;
            12: return m_gdir; 13: return m_gdbe; 14: return 32'(m_dbt);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) pipe[k] = 0;
        m_gdor = P_GDOR; m_goer = 0; m_gafr = 0; m_gper = P_GPER; m_gptr = P_GPTR;
        m_gier = 0; m_gim0 = 0; m_gim1 = 0; m_gifr = 0; m_gdir = 0; m_prev = 0;
        m_gdbe = 0; m_dbt = 0; m_irq = 0; rd_pend = 0; exp_rdata = 0;
        for (int i = 0; i < W; i++) m_cnt[i] = 0;
        rdq.delete();
    endtask

    always @(posedge clk) begin
        if (reset_n) begin
            logic [31:0] sv, ngdir, ev;
            sv = pipe[S-1];
            rd_pend = rd;
            if (rd) rdq.push_back(m_read(addr));
            ngdir = m_gdir;
            ev = 0;
            for (int i = 0; i < W; i++) begin
                int mode;
                if (!m_gdbe[i]) begin
                    ngdir[i] = sv[i]; m_cnt[i] = 0;
                end else if (sv[i] != m_gdir[i]) begin
                    if (m_cnt[i] >= m_dbt) begin ngdir[i] = sv[i]; m_cnt[i] = 0; end
                    else m_cnt[i] = m_cnt[i] + 1;
                end else m_cnt[i] = 0;
                mode = {m_gim1[i], m_gim0[i]};
                case (mode)
                    0: ev[i] = m_prev[i] && !m_gdir[i];
                    1: ev[i] = !m_prev[i] && m_gdir[i];
                    2: ev[i] = m_prev[i] != m_gdir[i];
                    default: ev[i] = m_gdir[i];
                endcase
            end
            ev = ev & m_gier & ~m_goer & ~m_gafr;
            if (wr && addr == 4'hB) m_gifr = m_gifr & ~wdata;
            m_gifr = m_gifr | ev;
            m_irq  = (m_gifr != 0);
            m_prev = m_gdir;
            m_gdir = ngdir;
            if (wr) begin
                case (addr)
                    0: m_gdor = wdata;           1: m_gdor = m_gdor | wdata;
                    2: m_gdor = m_gdor & ~wdata; 3: m_gdor = m_gdor ^ wdata;
                    4: m_goer = wdata;  5: m_gafr = wdata;  6: m_gper = wdata;
                    7: m_gptr = wdata;  8: m_gier = wdata;  9: m_gim0 = wdata;
                    10: m_gim1 = wdata; 13: m_gdbe = wdata; 14: m_dbt = int'(wdata[7:0]);
                    default: ;
                endcase
            end
            for (int k = S - 1; k > 0; k--) pipe[k] = pipe[k-1];
            pipe[0] = gpio_in;
        end
    end

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rdq.size() == 0) chk("read_queue_empty", 32'h1, 32'h0);
            else exp_rdata = rdq.pop_front();
            rd_pend = 0;
        end
        chk("rdata", rdata, exp_rdata);
        chk("gdor", gdor, m_gdor);
        chk("goer", goer, m_goer);
        chk("gafr", gafr, m_gafr);
        chk("pull_up", pull_up, m_gper & m_gptr);
        chk("pull_down", pull_down, m_gper & ~m_gptr);
        chk("irq", {31'h0, irq}, {31'h0, m_irq});
    end

    task automatic bus(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d);
        wr = w; rd = r; addr = a; wdata = d;
        @(negedge clk);
        wr = 0; rd = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        wr = 0; rd = 0; addr = 0; wdata = 0; gpio_in = 0;
        reset_n = 0;
        model_reset();
        idle(3);
        reset_n = 1;
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_gdor", gdor, P_GDOR);
        for (int a = 0; a < 16; a++) bus(0, 1, 4'(a), 0);

        bus(1, 0, 4'h0, 32'h0F);
        bus(1, 0, 4'h1, 32'hF0);
        chk("gdor_set", gdor, 32'hFF);
        bus(1, 0, 4'h2, 32'h0C);
        chk("gdor_clr", gdor, 32'hF3);
        bus(1, 0, 4'h3, 32'hFF);
        chk("gdor_inv", gdor, 32'h0C);

        bus(1, 0, 4'h8, 32'h1);
        bus(1, 0, 4'h9, 32'h1);
        gpio_in[0] = 1'b1;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (irq && lat == 0) lat = k;
        end
        chk("irq_latency", 32'(lat), 32'd4);
        bus(0, 1, 4'hB, 0);
        bus(1, 0, 4'hB, 32'h1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);
        gpio_in[0] = 1'b0;
        idle(6);
        bus(1, 0, 4'hB, 32'h1);

        bus(1, 0, 4'hD, 32'h1);
        bus(1, 0, 4'hE, 32'h5);
        gpio_in[0] = 1'b1; idle(4); gpio_in[0] = 1'b0; idle(10);
        chk("glitch_no_irq", {31'h0, irq}, 32'h0);
        bus(0, 1, 4'hC, 0);
        gpio_in[0] = 1'b1; idle(12);
        bus(0, 1, 4'hC, 0);
        chk("debounced_irq", {31'h0, irq}, 32'h1);
        gpio_in[0] = 1'b0; idle(12);
        bus(1, 0, 4'hB, 32'h1);

        bus(1, 0, 4'hD, 32'h0);
        bus(1, 0, 4'hA, 32'h1);
        gpio_in[0] = 1'b1; idle(6);
        for (int k = 0; k < 4; k++) begin
            bus(1, 0, 4'hB, 32'h1);
            chk("level_reassert", {31'h0, irq}, 32'h1);
        end
        bus(0, 1, 4'hB, 0);
        gpio_in[0] = 1'b0;
        bus(1, 0, 4'hA, 32'h0);
        idle(5);
        bus(1, 0, 4'hB, 32'h1);
        chk("irq_clear_before_edge", {31'h0, irq}, 32'h0);
        gpio_in[0] = 1'b1;
        idle(3);
        bus(1, 0, 4'hB, 32'h1);
        chk("edge_beats_w1c", {31'h0, irq}, 32'h1);
        gpio_in[0] = 1'b0; idle(5);
        bus(1, 0, 4'hB, 32'h1);

        bus(1, 0, 4'h4, 32'h1);
        gpio_in[0] = 1'b1; idle(6);
        bus(0, 1, 4'hC, 0);
        chk("goer_mask", {31'h0, irq}, 32'h0);
        bus(1, 0, 4'h4, 32'h0);
        bus(1, 0, 4'h5, 32'h1);
        gpio_in[0] = 1'b0; idle(3); gpio_in[0] = 1'b1; idle(6);
        chk("gafr_mask", {31'h0, irq}, 32'h0);
        bus(0, 1, 4'hB, 0);
        bus(1, 0, 4'h5, 32'h0);

        for (int it = 0; it < 2000; it++) begin
            logic [31:0] d;
            logic [3:0]  a;
            a = 4'($urandom_range(0, 15));
            d = $urandom();
            if (a == 4'hE) d = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 7) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) gpio_in = $urandom();
            if (it == 1000) begin
                #2 reset_n = 0;
                model_reset();
                idle(2);
                reset_n = 1;
            end
            bus($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a, d);
        end
        for (int a = 0; a < 16; a++) bus(0, 1, 4'(a), 0);
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
